ps2_host_tx: RTL and testbench

- PS/2 host-to-device transmitter. Sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard over the shared open-drain PS2_CLK/PS2_DATA lines.
- Counterpart of the keyboard scan-code receiver.
- Raises oBusy while it owns the bus, so the receive path can ignore frames during a transmission.

---
 rtl/ps2_host_tx.sv | 178 +++++++++++++++++
 tb/tb_ps2_host_tx.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- PS/2 host-to-device command transmitter.
//
// Sends one command byte to the device over the open-drain PS2_CLK/PS2_DATA
// pair: holds the clock low to request to send, drives the start bit, then
// shifts data/parity/stop on device-generated falling edges and samples the
// device ACK on the 11th falling edge. Outputs only ever request a pull-low;
// the tristate buffers live at the top level.
//
// Ports:
//   CLK          system clock
//   reset        asynchronous active-low reset
//   PS2_CLK      sensed PS/2 clock line level
//   PS2_DATA     sensed PS/2 data line level
//   iData[7:0]   command byte, sampled when iSend is accepted
//   iSend        one-cycle send request, accepted only when idle
//   oBusy        high while the transmitter owns the bus
//   oDone        one-cycle pulse at end of transaction
//   oError       one-cycle pulse with oDone on NACK or timeout
//   oClkDrvLow   1 = pull PS2_CLK low
//   oDataDrvLow  1 = pull PS2_DATA low
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 750000
) (
   input  logic       CLK,
   input  logic       reset,
   input  logic       PS2_CLK,
   input  logic       PS2_DATA,
   input  logic [7:0] iData,
   input  logic       iSend,
   output logic       oBusy,
   output logic       oDone,
   output logic       oError,
   output logic       oClkDrvLow,
   output logic       oDataDrvLow
);

   localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INHIBIT,
      S_START,
      S_SHIFT,
      S_WAIT_IDLE
   } state_t;

   state_t          state_q;
   logic [1:0]      clk_sync_q, data_sync_q;
   logic            clk_prev_q;
   logic [IW-1:0]   inh_cnt_q;
   logic [TW-1:0]   tmo_cnt_q;
   logic [3:0]      bit_cnt_q;
   logic [7:0]      shift_q;
   logic            par_q;
   logic            nack_q;
   logic            busy_q, done_q, err_q, clk_drv_q, data_drv_q;

   logic clk_s, data_s, fall;

   assign clk_s  = clk_sync_q[1];
   assign data_s = data_sync_q[1];
   assign fall   = clk_prev_q & ~clk_s;

   // Synchronisers reset to the idle (pulled-up) level so that leaving
   // reset never produces a spurious falling edge.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         clk_sync_q  <= 2'b11;
         data_sync_q <= 2'b11;
         clk_prev_q  <= 1'b1;
      end else begin
         clk_sync_q  <= {clk_sync_q[0], PS2_CLK};
         data_sync_q <= {data_sync_q[0], PS2_DATA};
         clk_prev_q  <= clk_s;
      end
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         inh_cnt_q  <= '0;
         tmo_cnt_q  <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         par_q      <= 1'b0;
         nack_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         clk_drv_q  <= 1'b0;
         data_drv_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               busy_q     <= 1'b0;
               clk_drv_q  <= 1'b0;
               data_drv_q <= 1'b0;
               if (iSend) begin
                  shift_q   <= iData;
                  par_q     <= ~^iData;
                  busy_q    <= 1'b1;
                  clk_drv_q <= 1'b1;
                  inh_cnt_q <= '0;
                  state_q   <= S_INHIBIT;
               end
            end
            S_INHIBIT: begin
               if (inh_cnt_q == INH_LAST) begin
                  data_drv_q <= 1'b1;    // start bit, clock still held
                  state_q    <= S_START;
               end else begin
                  inh_cnt_q <= inh_cnt_q + 1'b1;
               end
            end
            S_START: begin
               clk_drv_q <= 1'b0;        // hand the clock to the device
               bit_cnt_q <= '0;
               tmo_cnt_q <= '0;
               state_q   <= S_SHIFT;
            end
            S_SHIFT: begin
               tmo_cnt_q <= tmo_cnt_q + 1'b1;
               if (tmo_cnt_q == TMO_LAST) begin
                  clk_drv_q  <= 1'b0;
                  data_drv_q <= 1'b0;
                  done_q     <= 1'b0 | 1'b1;
                  err_q      <= 1'b1;
                  state_q    <= S_IDLE;
               end else if (fall) begin
                  // bit_cnt_q holds the edge count before this edge
                  bit_cnt_q <= bit_cnt_q + 1'b1;
                  case (bit_cnt_q)
                     4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7: begin
                        data_drv_q <= ~shift_q[0];
                        shift_q    <= {1'b0, shift_q[7:1]};
                     end
                     4'd8:    data_drv_q <= ~par_q;
                     4'd9:    data_drv_q <= 1'b0;   // stop bit: release
                     default: begin
                        nack_q  <= data_s;          // device pulls low to ACK
                        state_q <= S_WAIT_IDLE;
                     end
                  endcase
               end
            end
            S_WAIT_IDLE: begin
               tmo_cnt_q <= tmo_cnt_q + 1'b1;
               if (tmo_cnt_q == TMO_LAST) begin
                  clk_drv_q  <= 1'b0;
                  data_drv_q <= 1'b0;
                  done_q     <= 1'b1;
                  err_q      <= 1'b1;
                  state_q    <= S_IDLE;
               end else if (clk_s && data_s) begin
                  // busy_q stays high here; IDLE clears it one cycle later
                  done_q  <= 1'b1;
                  err_q   <= nack_q;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign oBusy       = busy_q;
   assign oDone       = done_q;
   assign oError      = err_q;
   assign oClkDrvLow  = clk_drv_q;
   assign oDataDrvLow = data_drv_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain bus model and a
// device that clocks at 80 CLK per bit.
module tb_ps2_host_tx;

   logic       CLK = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] iData = 8'h00;
   logic       iSend = 1'b0;
   logic       oBusy, oDone, oError, oClkDrvLow, oDataDrvLow;
   logic       dev_clk = 1'b1;   // 1 = device releases the line
   logic       dev_data = 1'b1;
   logic       ps2_clk, ps2_data;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int done_cnt = 0;

   assign ps2_clk  = dev_clk & ~oClkDrvLow;
   assign ps2_data = dev_data & ~oDataDrvLow;

   ps2_host_tx #(.INHIBIT_CYCLES(8), .TIMEOUT_CYCLES(3000)) dut (
      .CLK(CLK), .reset(reset), .PS2_CLK(ps2_clk), .PS2_DATA(ps2_data),
      .iData(iData), .iSend(iSend), .oBusy(oBusy), .oDone(oDone),
      .oError(oError), .oClkDrvLow(oClkDrvLow), .oDataDrvLow(oDataDrvLow)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      cyc <= cyc + 1;
      if (oDone === 1'b1) done_cnt <= done_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Request a send, measure the inhibit, then clock nclk device edges.
   // bits[i-1] holds the data level at device rising edge i.
   task automatic run_frame(input logic [7:0] d, input int nclk, input bit ack,
                            input bit mid_send, output logic [10:0] bits,
                            output int inh_len, output logic start_lvl,
                            output int rel_c);
      bits = '1;
      @(negedge CLK);
      iData = d;
      iSend = 1'b1;
      @(negedge CLK);
      iSend = 1'b0;
      iData = 8'h00;
      inh_len = 0;
      while (oClkDrvLow === 1'b1 && inh_len < 100) begin
         inh_len++;
         @(negedge CLK);
      end
      start_lvl = ps2_data;
      rel_c = cyc;
      repeat (20) @(negedge CLK);
      for (int i = 1; i <= nclk; i++) begin
         if (i == 11 && ack) dev_data = 1'b0;
         dev_clk = 1'b0;
         if (mid_send && i == 3) begin
            repeat (10) @(negedge CLK);
            iData = 8'h12;
            iSend = 1'b1;
            @(negedge CLK);
            iSend = 1'b0;
            iData = 8'h00;
            repeat (29) @(negedge CLK);
         end else begin
            repeat (40) @(negedge CLK);
         end
         bits[i-1] = ps2_data;
         dev_clk = 1'b1;
         dev_data = 1'b1;
         if (i < nclk) repeat (40) @(negedge CLK);
      end
   endtask

   task automatic wait_done(input int limit, output bit seen, output logic err,
                            output logic busy_at, output logic [1:0] drv,
                            output int dcyc, output logic busy_nxt);
      seen = 1'b0;
      err = 1'bx;
      busy_at = 1'bx;
      drv = 2'bxx;
      dcyc = -1;
      busy_nxt = 1'bx;
      for (int k = 0; k < limit; k++) begin
         @(negedge CLK);
         if (oDone === 1'b1) begin
            seen = 1'b1;
            err = oError;
            busy_at = oBusy;
            drv = {oClkDrvLow, oDataDrvLow};
            dcyc = cyc;
            break;
         end
      end
      if (seen) begin
         @(negedge CLK);
         busy_nxt = oBusy;
      end
   endtask

   initial begin
      logic [10:0] bits;
      int          inh_len, rel_c, dcyc, d0;
      logic        start_lvl, err, busy_at, busy_nxt;
      logic [1:0]  drv;
      bit          seen;

      // Reset state
      repeat (3) @(negedge CLK);
      chk("reset_outs", {oBusy, oDone, oError, oClkDrvLow, oDataDrvLow}, 5'b00000);
      reset = 1'b1;
      repeat (5) @(negedge CLK);

      // 1: 0xED with ACK
      run_frame(8'hED, 11, 1'b1, 1'b0, bits, inh_len, start_lvl, rel_c);
      wait_done(200, seen, err, busy_at, drv, dcyc, busy_nxt);
      chk("t1_clk_low_len", inh_len, 9);
      chk("t1_start_bit", start_lvl, 1'b0);
      chk("t1_frame", bits[9:0], 10'h3ED);
      chk("t1_ack_level", bits[10], 1'b0);
      chk("t1_done_seen", seen, 1'b1);
      chk("t1_error", err, 1'b0);
      chk("t1_busy_at_done", busy_at, 1'b1);
      chk("t1_busy_after", busy_nxt, 1'b0);
      repeat (20) @(negedge CLK);

      // 2: 0x00 with ACK
      run_frame(8'h00, 11, 1'b1, 1'b0, bits, inh_len, start_lvl, rel_c);
      wait_done(200, seen, err, busy_at, drv, dcyc, busy_nxt);
      chk("t2_frame", bits[9:0], 10'h300);
      chk("t2_done_seen", seen, 1'b1);
      chk("t2_error", err, 1'b0);
      repeat (20) @(negedge CLK);

      // 3: 0xFF, device NACKs
      run_frame(8'hFF, 11, 1'b0, 1'b0, bits, inh_len, start_lvl, rel_c);
      wait_done(200, seen, err, busy_at, drv, dcyc, busy_nxt);
      chk("t3_frame", bits[9:0], 10'h3FF);
      chk("t3_done_seen", seen, 1'b1);
      chk("t3_error", err, 1'b1);
      repeat (20) @(negedge CLK);

      // 4: device stops after 4 edges -> timeout 3000 cycles after release
      run_frame(8'h00, 4, 1'b0, 1'b0, bits, inh_len, start_lvl, rel_c);
      chk("t4_data_driven", oDataDrvLow, 1'b1);
      wait_done(4000, seen, err, busy_at, drv, dcyc, busy_nxt);
      chk("t4_done_seen", seen, 1'b1);
      chk("t4_timeout_cycles", dcyc - rel_c, 3000);
      chk("t4_error", err, 1'b1);
      chk("t4_lines_released", drv, 2'b00);
      chk("t4_busy_after", busy_nxt, 1'b0);
      repeat (20) @(negedge CLK);

      // 5: second iSend mid-frame is ignored
      d0 = done_cnt;
      run_frame(8'hED, 11, 1'b1, 1'b1, bits, inh_len, start_lvl, rel_c);
      wait_done(200, seen, err, busy_at, drv, dcyc, busy_nxt);
      chk("t5_frame", bits[9:0], 10'h3ED);
      chk("t5_error", err, 1'b0);
      repeat (200) @(negedge CLK);
      chk("t5_done_count", done_cnt - d0, 1);
      chk("t5_busy_idle", oBusy, 1'b0);

      // 6: async reset at n=5, then a clean 0xF4 frame
      run_frame(8'hED, 5, 1'b0, 1'b0, bits, inh_len, start_lvl, rel_c);
      chk("t6_pre_reset", {oBusy, oDataDrvLow}, 2'b11);
      #2;
      reset = 1'b0;
      #1;
      chk("t6_async_reset", {oBusy, oClkDrvLow, oDataDrvLow, oDone, oError}, 5'b00000);
      @(negedge CLK);
      reset = 1'b1;
      repeat (5) @(negedge CLK);
      run_frame(8'hF4, 11, 1'b1, 1'b0, bits, inh_len, start_lvl, rel_c);
      wait_done(200, seen, err, busy_at, drv, dcyc, busy_nxt);
      chk("t6_frame", bits[9:0], 10'h2F4);
      chk("t6_done_seen", seen, 1'b1);
      chk("t6_error", err, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
